// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 operator pipeline.
// Widths here are the defaults used by the phase generator.
package opl3_pkg;

    localparam int NUM_SLOTS       = 36;
    localparam int REG_FNUM_WIDTH  = 10;
    localparam int REG_BLOCK_WIDTH = 3;
    localparam int PHASE_ACC_WIDTH = 20;
    localparam int VIB_POS_WIDTH   = 3;
    localparam int MULTX2_WIDTH    = 5;

    typedef logic [$clog2(NUM_SLOTS)-1:0] slot_idx_t;
    typedef logic [MULTX2_WIDTH-1:0]      multx2_t;

    // Twice the frequency multiplier, so the 0.5x code stays integral.
    localparam multx2_t MULTX2 [16] = '{
        5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
        5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30
    };

    function automatic multx2_t multx2_of(input logic [3:0] mult);
        return MULTX2[mult];
    endfunction

endpackage

// File: rtl/phase_gen_mc_vib_pos_gen.sv
// Vibrato position counter: divides sample pulses down to
// a 3-bit position that steps once per 2^VIB_DIV_LOG2 pulses.
module vib_pos_gen #(
    parameter int VIB_DIV_LOG2 = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sample_clk_en_i,
    output logic [opl3_pkg::VIB_POS_WIDTH-1:0] vib_pos_o
);
    import opl3_pkg::*;

    localparam logic [VIB_DIV_LOG2-1:0]  DIV_ONE = 1;
    localparam logic [VIB_POS_WIDTH-1:0] POS_ONE = 1;

    logic [VIB_DIV_LOG2-1:0]  div_q, div_d;
    logic [VIB_POS_WIDTH-1:0] pos_q, pos_d;

    always_comb begin
        div_d = div_q;
        pos_d = pos_q;
        if (sample_clk_en_i) begin
            div_d = div_q + DIV_ONE;
            if (&div_q) begin
                pos_d = pos_q + POS_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            pos_q <= '0;
        end else begin
            div_q <= div_d;
            pos_q <= pos_d;
        end
    end

    assign vib_pos_o = pos_q;

endmodule

// File: rtl/phase_gen_mc.sv
// Time-multiplexed phase generator: vibrato + fnum/block/mult
// increment, then per-slot accumulator with key-on restart.
module phase_gen_mc #(
    parameter int NUM_SLOTS       = opl3_pkg::NUM_SLOTS,
    parameter int FNUM_WIDTH      = opl3_pkg::REG_FNUM_WIDTH,
    parameter int BLOCK_WIDTH     = opl3_pkg::REG_BLOCK_WIDTH,
    parameter int PHASE_ACC_WIDTH = opl3_pkg::PHASE_ACC_WIDTH,
    parameter int PHASE_OUT_WIDTH = 10,
    parameter int VIB_DIV_LOG2    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_clk_en,
    input  logic                         in_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] in_slot,
    input  logic [FNUM_WIDTH-1:0]        fnum,
    input  logic [BLOCK_WIDTH-1:0]       block,
    input  logic [3:0]                   mult,
    input  logic                         vib,
    input  logic                         dvb,
    input  logic                         key_on,
    output logic                         out_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] out_slot,
    output logic [PHASE_ACC_WIDTH-1:0]   phase_inc,
    output logic [PHASE_OUT_WIDTH-1:0]   phase_out
);
    import opl3_pkg::*;

    localparam int SW      = $clog2(NUM_SLOTS);
    localparam int FE_W    = FNUM_WIDTH + 1;
    localparam int SHIFT_W = FE_W + (2 ** BLOCK_WIDTH) - 1;
    localparam int PROD_W  = SHIFT_W + MULTX2_WIDTH;

    logic [VIB_POS_WIDTH-1:0] vib_pos;

    vib_pos_gen #(
        .VIB_DIV_LOG2(VIB_DIV_LOG2)
    ) u_vib_pos_gen (
        .clk             (clk),
        .reset           (reset),
        .sample_clk_en_i (sample_clk_en),
        .vib_pos_o       (vib_pos)
    );

    logic            in_ok;
    logic [2:0]      delta;
    logic [2:0]      half;
    logic            off_neg;
    logic [FE_W-1:0] off_mag;
    logic [FE_W-1:0] fnum_eff_d;

    assign in_ok = in_valid && (int'(in_slot) < NUM_SLOTS);

    // Offset is bounded by the top fnum bits, so subtraction never underflows.
    always_comb begin
        delta = fnum[FNUM_WIDTH-1 -: 3];
        if (!dvb) begin
            delta = {1'b0, delta[2:1]};
        end
        half    = {1'b0, delta[2:1]};
        off_mag = '0;
        off_neg = 1'b0;
        if (vib) begin
            unique case (vib_pos)
                3'd1, 3'd3: off_mag = FE_W'(half);
                3'd2:       off_mag = FE_W'(delta);
                3'd5, 3'd7: begin
                    off_mag = FE_W'(half);
                    off_neg = 1'b1;
                end
                3'd6: begin
                    off_mag = FE_W'(delta);
                    off_neg = 1'b1;
                end
                default: off_mag = '0;
            endcase
        end
        if (off_neg) begin
            fnum_eff_d = FE_W'(fnum) - off_mag;
        end else begin
            fnum_eff_d = FE_W'(fnum) + off_mag;
        end
    end

    logic                    v1_q;
    logic [SW-1:0]           slot1_q;
    logic [FE_W-1:0]         fe1_q;
    logic [BLOCK_WIDTH-1:0]  blk1_q;
    logic [MULTX2_WIDTH-1:0] mx1_q;
    logic                    key1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            slot1_q <= '0;
            fe1_q   <= '0;
            blk1_q  <= '0;
            mx1_q   <= '0;
            key1_q  <= 1'b0;
        end else begin
            v1_q <= in_ok;
            if (in_ok) begin
                slot1_q <= in_slot;
                fe1_q   <= fnum_eff_d;
                blk1_q  <= block;
                mx1_q   <= multx2_of(mult);
                key1_q  <= key_on;
            end
        end
    end

    logic [SHIFT_W-1:0]         base;
    logic [PROD_W-1:0]          prod;
    logic [PHASE_ACC_WIDTH-1:0] inc_d;

    always_comb begin
        base  = (SHIFT_W'(fe1_q) << blk1_q) >> 1;
        prod  = PROD_W'(base) * PROD_W'(mx1_q);
        inc_d = PHASE_ACC_WIDTH'(prod >> 1);
    end

    logic                       v2_q;
    logic [SW-1:0]              slot2_q;
    logic [PHASE_ACC_WIDTH-1:0] inc2_q;
    logic                       key2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_q    <= 1'b0;
            slot2_q <= '0;
            inc2_q  <= '0;
            key2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                slot2_q <= slot1_q;
                inc2_q  <= inc_d;
                key2_q  <= key1_q;
            end
        end
    end

    logic [PHASE_ACC_WIDTH-1:0] acc_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]       prev_key_q;
    logic [PHASE_ACC_WIDTH-1:0] acc_rd;
    logic [PHASE_ACC_WIDTH-1:0] acc_new;
    logic                       key_edge;

    // Read and write share one stage, so consecutive visits chain naturally.
    always_comb begin
        acc_rd   = acc_q[slot2_q];
        key_edge = key2_q & ~prev_key_q[slot2_q];
        acc_new  = key_edge ? '0 : acc_rd + inc2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                acc_q[i] <= '0;
            end
            prev_key_q <= '0;
            out_valid  <= 1'b0;
            out_slot   <= '0;
            phase_inc  <= '0;
            phase_out  <= '0;
        end else begin
            out_valid <= v2_q;
            if (v2_q) begin
                acc_q[slot2_q]      <= acc_new;
                prev_key_q[slot2_q] <= key2_q;
                out_slot            <= slot2_q;
                phase_inc           <= inc2_q;
                phase_out           <= acc_new[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_phase_gen_mc.sv
// Randomized bench for phase_gen_mc against a plain-arithmetic
// reference model, plus directed golden values.
module tb_phase_gen_mc;

    localparam int NS     = 36;
    localparam int VIB_L2 = 2;
    localparam int ACC_M  = 1 << 20;

    logic        clk;
    logic        reset;
    logic        sample_clk_en;
    logic        in_valid;
    logic [5:0]  in_slot;
    logic [9:0]  fnum;
    logic [2:0]  block;
    logic [3:0]  mult;
    logic        vib;
    logic        dvb;
    logic        key_on;
    logic        out_valid;
    logic [5:0]  out_slot;
    logic [19:0] phase_inc;
    logic [9:0]  phase_out;

    phase_gen_mc #(
        .VIB_DIV_LOG2(VIB_L2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_clk_en (sample_clk_en),
        .in_valid      (in_valid),
        .in_slot       (in_slot),
        .fnum          (fnum),
        .block         (block),
        .mult          (mult),
        .vib           (vib),
        .dvb           (dvb),
        .key_on        (key_on),
        .out_valid     (out_valid),
        .out_slot      (out_slot),
        .phase_inc     (phase_inc),
        .phase_out     (phase_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int slot;
        int inc;
        int pout;
        int ginc;
        int gout;
    } exp_t;

    exp_t q[$];
    int   macc[NS];
    bit   mprev[NS];
    int   pulses;
    int   mx2[16] = '{1, 2, 4, 6, 8, 10, 12, 14,
                      16, 18, 20, 20, 24, 24, 30, 30};

    function automatic int model_inc(int f, int b, int m, bit vb, bit dv,
                                     int pos);
        int d;
        int h;
        int offs[8];
        int fe;
        d = f / 128;
        if (!dv) d = d / 2;
        h = d / 2;
        offs = '{0, h, d, h, 0, -h, -d, -h};
        fe = f + (vb ? offs[pos] : 0);
        return ((((fe * (1 << b)) / 2) * mx2[m]) / 2) % ACC_M;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            macc[i]  = 0;
            mprev[i] = 1'b0;
        end
        pulses = 0;
        q.delete();
    endtask

    task automatic model_accept(int s, int f, int b, int m, bit vb, bit dv,
                                bit k, int gi, int go);
        exp_t e;
        int   inc;
        inc = model_inc(f, b, m, vb, dv, (pulses >> VIB_L2) % 8);
        if (k && !mprev[s]) macc[s] = 0;
        else macc[s] = (macc[s] + inc) % ACC_M;
        mprev[s] = k;
        e.cyc  = cyc + 3;
        e.slot = s;
        e.inc  = inc;
        e.pout = macc[s] / 1024;
        e.ginc = gi;
        e.gout = go;
        q.push_back(e);
    endtask

    task automatic drive(bit v, int s, int f, int b, int m, bit vb, bit dv,
                         bit k, bit se, int gi, int go);
        @(posedge clk);
        #1;
        in_valid      = v;
        in_slot       = 6'(s);
        fnum          = 10'(f);
        block         = 3'(b);
        mult          = 4'(m);
        vib           = vb;
        dvb           = dv;
        key_on        = k;
        sample_clk_en = se;
        if (v && s < NS) model_accept(s, f, b, m, vb, dv, k, gi, go);
        if (se) pulses++;
    endtask

    task automatic idle(int n, bit se);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, se, -1, -1);
    endtask

    always @(negedge clk) begin
        bit   expv;
        exp_t e;
        if (mon_on) begin
            expv = (q.size() > 0) && (q[0].cyc == cyc);
            check("out_valid", 32'(out_valid), 32'(expv));
            if (expv) begin
                e = q.pop_front();
                if (out_valid) begin
                    check("out_slot", 32'(out_slot), 32'(e.slot));
                    check("phase_inc", 32'(phase_inc), 32'(e.inc));
                    check("phase_out", 32'(phase_out), 32'(e.pout));
                    if (e.ginc >= 0)
                        check("gold_inc", 32'(phase_inc), 32'(e.ginc));
                    if (e.gout >= 0)
                        check("gold_out", 32'(phase_out), 32'(e.gout));
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int kst[40];

    initial begin
        int s;
        reset = 1'b1;
        sample_clk_en = 0; in_valid = 0; in_slot = 0; fnum = 0;
        block = 0; mult = 0; vib = 0; dvb = 0; key_on = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_slot", 32'(out_slot), 0);
        check("rst_inc", 32'(phase_inc), 0);
        check("rst_out", 32'(phase_out), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1'b1;

        drive(1, 5, 'h200, 4, 1, 0, 0, 1, 0, 4096, 0);
        idle(2, 0);
        drive(1, 5, 'h200, 4, 1, 0, 0, 1, 0, 4096, 4);
        drive(1, 5, 'h200, 4, 0, 0, 0, 1, 0, 2048, -1);
        drive(1, 5, 'h200, 4, 'hB, 0, 0, 1, 0, 40960, -1);
        drive(1, 5, 'h200, 4, 'hE, 0, 0, 1, 0, 61440, -1);
        drive(1, 7, 1023, 7, 'hF, 0, 0, 1, 0, 982080, 0);
        drive(1, 7, 1023, 7, 'hF, 0, 0, 1, 0, 982080, 959);
        drive(1, 7, 1023, 7, 'hF, 0, 0, 1, 0, 982080, 894);
        idle(4, 0);

        drive(1, 9, 'h380, 0, 1, 1, 1, 1, 0, 448, -1);
        idle(4, 1);
        drive(1, 9, 'h380, 0, 1, 1, 1, 1, 0, 449, -1);
        idle(4, 1);
        drive(1, 9, 'h380, 0, 1, 1, 1, 1, 0, 451, -1);
        drive(1, 9, 'h380, 0, 1, 1, 0, 1, 0, 449, -1);
        idle(16, 1);
        drive(1, 9, 'h380, 0, 1, 1, 1, 1, 0, 444, -1);
        idle(4, 0);

        for (int i = 0; i < 20; i++)
            drive(1, i % 2, (i % 2) ? 300 : 777, 5, 3, 0, 0, 1, 0, -1, -1);
        for (int i = 0; i < 10; i++)
            drive(1, 2, 513, 6, 7, 0, 0, 1, 0, -1, -1);
        idle(4, 0);

        for (int i = 0; i < 40; i++) kst[i] = 0;
        for (int i = 0; i < 3000; i++) begin
            s = $urandom_range(0, 39);
            if ($urandom_range(0, 4) == 0) kst[s] = 1 - kst[s];
            drive($urandom_range(0, 9) < 7, s, $urandom_range(0, 1023),
                  $urandom_range(0, 7), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'(kst[s]), $urandom_range(0, 9) < 3, -1, -1);
        end

        drive(1, 7, 1023, 7, 'hF, 0, 0, 0, 0, -1, -1);
        drive(1, 8, 200, 3, 2, 0, 0, 1, 0, -1, -1);
        @(posedge clk);
        #1;
        in_slot = 6'd9;
        reset = 1'b1;
        model_reset();
        idle(2, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(4, 0);

        drive(1, 7, 1023, 7, 'hF, 0, 0, 0, 0, 982080, 959);
        drive(1, 9, 'h380, 0, 1, 1, 1, 1, 0, 448, 0);
        drive(1, 5, 'h200, 4, 1, 0, 0, 1, 0, 4096, 0);
        idle(1, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
